// File: rtl/pwm_reg_bank.sv
// rtl/pwm_reg_bank.sv - shadowed duty/period register bank for a multi-channel PWM with rollover commit
// Optional err_count output is enabled by defining PWM_REG_BANK_ERR_CNT_EN.
module pwm_reg_bank #(
  parameter int              WIDTH      = 8,
  parameter int              CHANNELS   = 4,
  parameter logic [WIDTH-1:0] RST_PERIOD = {WIDTH{1'b1}},
  localparam int             CW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [CW-1:0]             wr_ch,
  input  logic [WIDTH-1:0]          wr_duty,
  input  logic [WIDTH-1:0]          wr_period,
  input  logic                      sync_mode,
  input  logic [CHANNELS-1:0]       rollover,
  input  logic                      err_clr,
  output logic [CHANNELS*WIDTH-1:0] duty_flat,
  output logic [CHANNELS*WIDTH-1:0] period_flat,
  output logic [CHANNELS-1:0]       pending,
  output logic [CHANNELS-1:0]       upd_done,
  output logic                      err
`ifdef PWM_REG_BANK_ERR_CNT_EN
  ,
  output logic [7:0]                err_count
`endif
);

  // Every decodable index gets a mask bit, so out-of-range channels decode to 0.
  localparam int NSLOT = 1 << CW;
  localparam logic [NSLOT-1:0] CH_MASK = {NSLOT{1'b1}} >> (NSLOT - CHANNELS);

  logic ch_ok;
  logic wr_ok;
  logic wr_reject;

  assign ch_ok     = CH_MASK[wr_ch];
  assign wr_ok     = wr_en & ch_ok & (wr_period != '0) & (wr_duty <= wr_period);
  assign wr_reject = wr_en & ~(ch_ok & (wr_period != '0) & (wr_duty <= wr_period));

  for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
    logic [WIDTH-1:0] sh_duty;
    logic [WIDTH-1:0] sh_period;
    logic [WIDTH-1:0] act_duty;
    logic [WIDTH-1:0] act_period;
    logic             pend_r;
    logic             done_r;
    logic             wr_hit;
    logic             commit;

    assign wr_hit = wr_ok & (wr_ch == CW'(n));
    // Commit looks only at state registered before this edge; a same-cycle write stays in shadow.
    assign commit = pend_r & (sync_mode ? rollover[0] : rollover[n]);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sh_duty    <= '0;
        sh_period  <= '0;
        act_duty   <= '0;
        act_period <= RST_PERIOD;
        pend_r     <= 1'b0;
        done_r     <= 1'b0;
      end else begin
        done_r <= commit;
        if (commit) begin
          act_duty   <= sh_duty;
          act_period <= sh_period;
        end
        if (wr_hit) begin
          sh_duty   <= wr_duty;
          sh_period <= wr_period;
          pend_r    <= 1'b1;
        end else if (commit) begin
          pend_r <= 1'b0;
        end
      end
    end

    assign duty_flat[n*WIDTH +: WIDTH]   = act_duty;
    assign period_flat[n*WIDTH +: WIDTH] = act_period;
    assign pending[n]                    = pend_r;
    assign upd_done[n]                   = done_r;
  end

  // A reject in the clear cycle wins so the event is never lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (wr_reject) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end

`ifdef PWM_REG_BANK_ERR_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= 8'd0;
    end else if (err_clr) begin
      err_count <= wr_reject ? 8'd1 : 8'd0;
    end else if (wr_reject && err_count != 8'hFF) begin
      err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pwm_reg_bank.sv
// tb/tb_pwm_reg_bank.sv - directed self-checking bench for pwm_reg_bank
// Checks err_count as well when PWM_REG_BANK_ERR_CNT_EN is defined.
module tb_pwm_reg_bank;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_ch = '0;
  logic [7:0]  wr_duty = '0;
  logic [7:0]  wr_period = '0;
  logic        sync_mode = 1'b0;
  logic [3:0]  rollover = '0;
  logic        err_clr = 1'b0;
  logic [31:0] duty_flat;
  logic [31:0] period_flat;
  logic [3:0]  pending;
  logic [3:0]  upd_done;
  logic        err;
`ifdef PWM_REG_BANK_ERR_CNT_EN
  logic [7:0]  err_count;
`endif

  int passed = 0;
  int total  = 0;

  pwm_reg_bank dut (
    .clk(clk),
    .rst(rst),
    .wr_en(wr_en),
    .wr_ch(wr_ch),
    .wr_duty(wr_duty),
    .wr_period(wr_period),
    .sync_mode(sync_mode),
    .rollover(rollover),
    .err_clr(err_clr),
    .duty_flat(duty_flat),
    .period_flat(period_flat),
    .pending(pending),
    .upd_done(upd_done),
    .err(err)
`ifdef PWM_REG_BANK_ERR_CNT_EN
    ,
    .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [1:0] ch, input logic [7:0] d, input logic [7:0] p);
    wr_en = 1'b1; wr_ch = ch; wr_duty = d; wr_period = p;
  endtask

  task automatic idle();
    wr_en = 1'b0; rollover = '0; err_clr = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    total++; if (duty_flat !== 32'h0) $display("FAIL reset_duty got %h want %h", duty_flat, 32'h0); else passed++;
    total++; if (period_flat !== 32'hFFFFFFFF) $display("FAIL reset_period got %h want %h", period_flat, 32'hFFFFFFFF); else passed++;
    total++; if (pending !== 4'b0) $display("FAIL reset_pending got %b want 0000", pending); else passed++;
    total++; if (upd_done !== 4'b0 || err !== 1'b0) $display("FAIL reset_done_err got %b/%b want 0000/0", upd_done, err); else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    write(2'd1, 8'd40, 8'd100);
    tick(); idle();
    total++; if (pending !== 4'b0010) $display("FAIL basic_pending_set got %b want 0010", pending); else passed++;
    total++; if (duty_flat[15:8] !== 8'd0) $display("FAIL basic_no_early_commit got %0d want 0", duty_flat[15:8]); else passed++;
    rollover = 4'b0010;
    tick(); idle();
    total++; if (pending !== 4'b0000) $display("FAIL basic_pending_clr got %b want 0000", pending); else passed++;
    total++; if (upd_done !== 4'b0010) $display("FAIL basic_upd_done got %b want 0010", upd_done); else passed++;
    total++; if (duty_flat[15:8] !== 8'd40 || period_flat[15:8] !== 8'd100)
      $display("FAIL basic_active got %0d/%0d want 40/100", duty_flat[15:8], period_flat[15:8]); else passed++;
    rollover = 4'b0010;
    tick(); idle();
    total++; if (upd_done !== 4'b0000) $display("FAIL basic_single_pulse got %b want 0000", upd_done); else passed++;
  endtask

  task automatic test_reject();
    write(2'd2, 8'd120, 8'd100);
    tick(); idle();
    total++; if (err !== 1'b1 || pending !== 4'b0) $display("FAIL rej_duty_gt_period err=%b pend=%b want 1/0000", err, pending); else passed++;
    write(2'd2, 8'd0, 8'd0);
    tick(); idle();
    total++; if (pending[2] !== 1'b0) $display("FAIL rej_period0_pending got %b want 0", pending[2]); else passed++;
    rollover = 4'b0100;
    tick(); idle();
    total++; if (duty_flat[23:16] !== 8'd0 || period_flat[23:16] !== 8'd255 || upd_done !== 4'b0)
      $display("FAIL rej_ch2_unchanged got %0d/%0d done=%b want 0/255 0000", duty_flat[23:16], period_flat[23:16], upd_done); else passed++;
`ifdef PWM_REG_BANK_ERR_CNT_EN
    total++; if (err_count !== 8'd2) $display("FAIL rej_err_count got %0d want 2", err_count); else passed++;
`endif
    err_clr = 1'b1;
    tick(); idle();
    total++; if (err !== 1'b0) $display("FAIL err_clr got %b want 0", err); else passed++;
    err_clr = 1'b1;
    write(2'd0, 8'd5, 8'd4);
    tick(); idle();
    total++; if (err !== 1'b1) $display("FAIL err_clr_with_reject got %b want 1", err); else passed++;
`ifdef PWM_REG_BANK_ERR_CNT_EN
    total++; if (err_count !== 8'd1) $display("FAIL err_count_clr_reject got %0d want 1", err_count); else passed++;
`endif
    err_clr = 1'b1;
    tick(); idle();
  endtask

  task automatic test_boundary();
    write(2'd2, 8'd100, 8'd100);
    tick(); idle();
    total++; if (pending !== 4'b0100 || err !== 1'b0) $display("FAIL bnd_duty_eq_period pend=%b err=%b want 0100/0", pending, err); else passed++;
    rollover = 4'b0100;
    tick(); idle();
    total++; if (duty_flat[23:16] !== 8'd100 || period_flat[23:16] !== 8'd100)
      $display("FAIL bnd_commit got %0d/%0d want 100/100", duty_flat[23:16], period_flat[23:16]); else passed++;
  endtask

  task automatic test_sync();
    sync_mode = 1'b1;
    write(2'd0, 8'd10, 8'd50);
    tick();
    write(2'd3, 8'd20, 8'd60);
    tick(); idle();
    total++; if (pending !== 4'b1001) $display("FAIL sync_pending got %b want 1001", pending); else passed++;
    rollover = 4'b1000;
    tick(); idle();
    total++; if (pending !== 4'b1001 || upd_done !== 4'b0 || period_flat[31:24] !== 8'd255)
      $display("FAIL sync_ignore_ro3 pend=%b done=%b p3=%0d want 1001/0000/255", pending, upd_done, period_flat[31:24]); else passed++;
    rollover = 4'b0001;
    tick(); idle();
    total++; if (pending !== 4'b0 || upd_done !== 4'b1001) $display("FAIL sync_commit pend=%b done=%b want 0000/1001", pending, upd_done); else passed++;
    total++; if (duty_flat[7:0] !== 8'd10 || period_flat[7:0] !== 8'd50 || duty_flat[31:24] !== 8'd20 || period_flat[31:24] !== 8'd60)
      $display("FAIL sync_values got %0d/%0d %0d/%0d want 10/50 20/60", duty_flat[7:0], period_flat[7:0], duty_flat[31:24], period_flat[31:24]); else passed++;
    sync_mode = 1'b0;
  endtask

  task automatic test_same_cycle();
    write(2'd1, 8'd30, 8'd90);
    rollover = 4'b0010;
    tick(); idle();
    total++; if (pending !== 4'b0010 || upd_done !== 4'b0) $display("FAIL same_cycle_no_commit pend=%b done=%b want 0010/0000", pending, upd_done); else passed++;
    total++; if (duty_flat[15:8] !== 8'd40 || period_flat[15:8] !== 8'd100)
      $display("FAIL same_cycle_hold got %0d/%0d want 40/100", duty_flat[15:8], period_flat[15:8]); else passed++;
    rollover = 4'b0010;
    tick(); idle();
    total++; if (duty_flat[15:8] !== 8'd30 || period_flat[15:8] !== 8'd90 || upd_done !== 4'b0010)
      $display("FAIL same_cycle_later_commit got %0d/%0d done=%b want 30/90 0010", duty_flat[15:8], period_flat[15:8], upd_done); else passed++;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) begin
      write(2'(i), 8'd1, 8'd2);
      tick();
    end
    write(2'd0, 8'd9, 8'd3);
    tick(); idle();
    total++; if (pending !== 4'b1111 || err !== 1'b1) $display("FAIL mid_setup pend=%b err=%b want 1111/1", pending, err); else passed++;
    #2 rst = 1'b1;
    #1;
    total++; if (duty_flat !== 32'h0 || period_flat !== 32'hFFFFFFFF)
      $display("FAIL mid_async_active got %h/%h want 0/ffffffff", duty_flat, period_flat); else passed++;
    total++; if (pending !== 4'b0 || upd_done !== 4'b0 || err !== 1'b0)
      $display("FAIL mid_async_flags pend=%b done=%b err=%b want 0000/0000/0", pending, upd_done, err); else passed++;
    #1 rst = 1'b0;
    rollover = 4'b1111;
    tick(); idle();
    total++; if (upd_done !== 4'b0 || period_flat !== 32'hFFFFFFFF || duty_flat !== 32'h0)
      $display("FAIL mid_no_commit done=%b active=%h/%h want 0000 0/ffffffff", upd_done, duty_flat, period_flat); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reject();
    test_boundary();
    test_sync();
    test_same_cycle();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
